// File: rtl/wb_queue.sv
// wb_queue: in-order write-back FIFO feeding the regfile write port, with forwarding lookup.
// Optional build macro WB_COALESCE_EN merges a push into the youngest entry with the same rd.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_val,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_val,
    output logic            w_enable,
    output logic [4:0]      w_reg_name,
    output logic [XLEN-1:0] w_reg_val,
    input  logic [4:0]      fwd_name,
    output logic            fwd_hit,
    output logic [XLEN-1:0] fwd_val,
    output logic            empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [4:0]      rd_q  [DEPTH];
    logic [XLEN-1:0] val_q [DEPTH];

    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            full;
    logic            pop;
    logic            lsu_match;
    logic            alu_match;
    logic            lsu_fire;
    logic            alu_fire;
    logic            in_match;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] in_val;
    logic            enq;
    logic            merge;

`ifdef WB_COALESCE_EN
    logic [PW-1:0]   young;

    // Youngest entry may absorb a same-rd push; with one entry it is the head being popped.
    always_comb begin
        young     = wr_ptr - PW'(1);
        lsu_match = (count > CW'(1)) && (lsu_rd != 5'd0) && (rd_q[young] == lsu_rd);
        alu_match = (count > CW'(1)) && (alu_rd != 5'd0) && (rd_q[young] == alu_rd);
    end
`else
    assign lsu_match = 1'b0;
    assign alu_match = 1'b0;
`endif

    // Handshake: readiness from pre-pop count, LSU has fixed priority, one push per cycle.
    always_comb begin
        full      = (count == FULL_CNT);
        pop       = (count != '0);
        lsu_ready = !full || lsu_match;
        alu_ready = (!full || alu_match) && !lsu_valid;
        lsu_fire  = lsu_valid && lsu_ready;
        alu_fire  = alu_valid && alu_ready;
        in_rd     = lsu_fire ? lsu_rd    : alu_rd;
        in_val    = lsu_fire ? lsu_val   : alu_val;
        in_match  = lsu_fire ? lsu_match : alu_match;
        enq       = (lsu_fire || alu_fire) && (in_rd != 5'd0) && !in_match && !rst;
        merge     = (lsu_fire || alu_fire) && (in_rd != 5'd0) && in_match && !rst;
    end

    // Entry storage: allocate at the write pointer or overwrite the youngest value.
    always_ff @(posedge clk) begin
        if (enq) begin
            rd_q[wr_ptr]  <= in_rd;
            val_q[wr_ptr] <= in_val;
        end
`ifdef WB_COALESCE_EN
        else if (merge) begin
            val_q[young] <= in_val;
        end
`endif
    end

    // Pointers, occupancy and the registered regfile write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            w_enable   <= 1'b0;
            w_reg_name <= 5'd0;
            w_reg_val  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                w_enable   <= 1'b1;
                w_reg_name <= rd_q[rd_ptr];
                w_reg_val  <= val_q[rd_ptr];
                rd_ptr     <= rd_ptr + PW'(1);
            end else begin
                w_enable <= 1'b0;
            end
            if (enq && !pop) begin
                count <= count + CW'(1);
            end else if (!enq && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Forwarding: output register is oldest, later FIFO entries override earlier matches.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        fwd_hit = 1'b0;
        fwd_val = '0;
        if (fwd_name != 5'd0) begin
            if (w_enable && (w_reg_name == fwd_name)) begin
                fwd_hit = 1'b1;
                fwd_val = w_reg_val;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PW'(i);
                if ((CW'(i) < count) && (rd_q[idx] == fwd_name)) begin
                    fwd_hit = 1'b1;
                    fwd_val = val_q[idx];
                end
            end
        end
    end

    assign empty = (count == '0) && !w_enable;

endmodule
